// File: rtl/ov7670_sccb_config_pkg.sv
// ov7670_pkg: shared types and constants for the OV7670 SCCB configuration
// sequencer.
//   state_t        sequencer states
//   SCCB_DEV_ADDR  OV7670 write address (7-bit 0x21 plus write bit)
//   CFG_END        table end marker
//   CFG_DELAY      table delay marker (inserts a DELAY_CYCLES wait)
//   is_ack_bit()   true for the 9th (don't-care / ACK) bit of each phase
package ov7670_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_FETCH = 3'd2,
    ST_START = 3'd3,
    ST_BITS  = 3'd4,
    ST_STOP  = 3'd5,
    ST_GAP   = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  localparam logic [7:0]  SCCB_DEV_ADDR = 8'h42;
  localparam logic [15:0] CFG_END       = 16'hFFFF;
  localparam logic [15:0] CFG_DELAY     = 16'hFFF0;
  localparam logic [4:0]  LAST_BIT      = 5'd26;

  function automatic logic is_ack_bit(input logic [4:0] b);
    return (b == 5'd8) || (b == 5'd17) || (b == 5'd26);
  endfunction

endpackage

// File: rtl/ov7670_sccb_config_if.sv
// ov7670_sccb_config_if: control/status and SCCB pin bundle of the sequencer.
//   start      request to (re)run the table (single cycle)
//   sio_c      SCCB clock
//   sio_d_out  SIO_D drive value
//   sio_d_oe   1 = drive sio_d_out, 0 = release (pulled high)
//   busy/done  sequence in progress / table completed
//   cfg_idx    current table index (debug)
// master = sequencer side, slave = system/top-level side.
interface ov7670_sccb_config_if;
  logic       start;
  logic       sio_c;
  logic       sio_d_out;
  logic       sio_d_oe;
  logic       busy;
  logic       done;
  logic [5:0] cfg_idx;

  modport master (
    input  start,
    output sio_c, sio_d_out, sio_d_oe, busy, done, cfg_idx
  );

  modport slave (
    output start,
    input  sio_c, sio_d_out, sio_d_oe, busy, done, cfg_idx
  );
endinterface

// File: rtl/ov7670_config_rom.sv
// ov7670_config_rom: combinational 64x16 register table, {reg, val} per entry.
//   i_addr  table index
//   o_data  entry; FFF0 = delay marker, FFFF = end marker
// Contents: soft reset, settle delay, QVGA RGB565, then QQVGA 160x120 scaling.
module ov7670_config_rom (
  input  logic [5:0]  i_addr,
  output logic [15:0] o_data
);

  always_comb begin
    o_data = 16'hFFFF;
    case (i_addr)
      6'd0:  o_data = 16'h12_80; // COM7: soft reset
      6'd1:  o_data = 16'hFFF0; // let the sensor come out of reset
      6'd2:  o_data = 16'h12_14; // COM7: QVGA, RGB
      6'd3:  o_data = 16'h40_D0; // COM15: RGB565, full range
      6'd4:  o_data = 16'h3A_04; // TSLB
      6'd5:  o_data = 16'h0C_04; // COM3: enable scaling
      6'd6:  o_data = 16'h3E_1A; // COM14: manual scaling, PCLK /4
      6'd7:  o_data = 16'h70_3A; // SCALING_XSC
      6'd8:  o_data = 16'h71_35; // SCALING_YSC
      6'd9:  o_data = 16'h72_22; // SCALING_DCWCTR: downsample by 4
      6'd10: o_data = 16'h73_F2; // SCALING_PCLK_DIV: /4
      6'd11: o_data = 16'hA2_02; // SCALING_PCLK_DELAY
      6'd12: o_data = 16'h17_16; // HSTART
      6'd13: o_data = 16'h18_04; // HSTOP
      6'd14: o_data = 16'h32_A4; // HREF
      6'd15: o_data = 16'h19_02; // VSTART
      6'd16: o_data = 16'h1A_7A; // VSTOP
      6'd17: o_data = 16'h03_0A; // VREF
      default: o_data = 16'hFFFF;
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// ov7670_sccb_config: walks ov7670_config_rom and issues one SCCB 3-phase
// write (dev addr, reg, val; ACK ignored) per entry. Runs once after reset
// when AUTO_START is set, and again on bus.start while idle/done.
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    ov7670_sccb_config_if.master (start in; SCCB pins, busy, done,
//          cfg_idx out)
// Bus outputs are decoded from registered state, so an asserted reset
// releases the bus in the same cycle.
module ov7670_sccb_config
  import ov7670_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
  parameter int unsigned SCCB_FREQ_HZ = 100_000,
  parameter int unsigned DELAY_CYCLES = 1_000_000,
  parameter bit          AUTO_START   = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  ov7670_sccb_config_if.master bus
);

  localparam int unsigned QTR_RAW = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int unsigned QTR     = (QTR_RAW < 2) ? 2 : QTR_RAW;
  localparam int unsigned QW      = $clog2(QTR);
  localparam int unsigned DW      = $clog2(DELAY_CYCLES + 1);

  state_t          r_state;
  logic [5:0]      r_idx;
  logic [DW-1:0]   r_dly;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_q;
  logic [4:0]      r_bit;
  logic [26:0]     r_frame;

  logic [15:0]     w_rom;
  logic [15:0]     w_entry;
  logic            w_qend;
  logic            w_sio_c;
  logic            w_sda_out;
  logic            w_sda_oe;

  ov7670_config_rom u_rom (
    .i_addr (r_idx),
    .o_data (w_rom)
  );

  // The last slot is never fetched as data, so a table without an end
  // marker still terminates.
  assign w_entry = (r_idx == 6'd63) ? CFG_END : w_rom;
  assign w_qend  = (r_qcnt == QW'(QTR - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_dly   <= '0;
      r_qcnt  <= '0;
      r_q     <= '0;
      r_bit   <= '0;
      r_frame <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (AUTO_START || bus.start) begin
            r_state <= ST_WAIT;
            r_idx   <= '0;
            r_dly   <= '0;
          end
        end
        ST_WAIT: begin
          if (r_dly == DW'(DELAY_CYCLES - 1)) begin
            r_dly   <= '0;
            r_state <= ST_FETCH;
          end else begin
            r_dly <= r_dly + 1'b1;
          end
        end
        ST_FETCH: begin
          r_qcnt <= '0;
          r_q    <= '0;
          r_bit  <= '0;
          if (w_entry == CFG_END) begin
            r_state <= ST_DONE;
          end else if (w_entry == CFG_DELAY) begin
            r_idx   <= r_idx + 1'b1;
            r_state <= ST_WAIT;
          end else begin
            // ACK slots hold a dummy 1; they are never driven.
            r_frame <= {SCCB_DEV_ADDR, 1'b1, w_entry[15:8], 1'b1,
                        w_entry[7:0], 1'b1};
            r_state <= ST_START;
          end
        end
        ST_START, ST_BITS, ST_STOP, ST_GAP: begin
          r_qcnt <= w_qend ? '0 : r_qcnt + 1'b1;
          if (w_qend) begin
            r_q <= r_q + 1'b1;
            case (r_state)
              ST_START: if (r_q == 2'd1) begin
                r_q     <= '0;
                r_state <= ST_BITS;
              end
              ST_BITS: if (r_q == 2'd3) begin
                // r_q wraps to 0 naturally at each bit boundary
                if (r_bit == LAST_BIT) begin
                  r_state <= ST_STOP;
                end else begin
                  r_bit   <= r_bit + 1'b1;
                  r_frame <= {r_frame[25:0], 1'b0};
                end
              end
              ST_STOP: if (r_q == 2'd2) begin
                r_q     <= '0;
                r_state <= ST_GAP;
              end
              default: if (r_q == 2'd3) begin
                r_q     <= '0;
                r_idx   <= r_idx + 1'b1;
                r_state <= ST_FETCH;
              end
            endcase
          end
        end
        ST_DONE: begin
          if (bus.start) begin
            r_idx   <= '0;
            r_dly   <= '0;
            r_state <= ST_WAIT;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_sio_c   = 1'b1;
    w_sda_out = 1'b1;
    w_sda_oe  = 1'b0;
    case (r_state)
      ST_START: begin
        w_sda_oe  = 1'b1;
        w_sda_out = (r_q == 2'd0);
      end
      ST_BITS: begin
        w_sio_c = (r_q == 2'd1) || (r_q == 2'd2);
        if (!is_ack_bit(r_bit)) begin
          w_sda_oe  = 1'b1;
          w_sda_out = r_frame[26];
        end
      end
      ST_STOP: begin
        w_sio_c   = (r_q != 2'd0);
        w_sda_oe  = 1'b1;
        w_sda_out = (r_q == 2'd2);
      end
      default: ;
    endcase
  end

  assign bus.sio_c     = w_sio_c;
  assign bus.sio_d_out = w_sda_out;
  assign bus.sio_d_oe  = w_sda_oe;
  assign bus.busy      = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign bus.done      = (r_state == ST_DONE);
  assign bus.cfg_idx   = r_idx;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb_ov7670_sccb_config: directed bench for ov7670_sccb_config with QTR=4 and
// a 20-cycle delay. A passive bus monitor decodes SCCB writes from the pins;
// scenario tasks compare the decoded writes and status outputs against
// hand-written expectations.
module tb_ov7670_sccb_config;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ov7670_sccb_config_if bus ();

  ov7670_sccb_config #(
    .CLK_FREQ_HZ  (16),
    .SCCB_FREQ_HZ (1),
    .DELAY_CYCLES (20),
    .AUTO_START   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [26:0] REL_MASK = 27'b000000001_000000001_000000001;
  localparam int NWR = 17;
  logic [23:0] exp_tx [NWR] = '{
    24'h421280, 24'h421214, 24'h4240D0, 24'h423A04, 24'h420C04, 24'h423E1A,
    24'h42703A, 24'h427135, 24'h427222, 24'h4273F2, 24'h42A202, 24'h421716,
    24'h421804, 24'h4232A4, 24'h421902, 24'h421A7A, 24'h42030A
  };

  int n_vec = 0;
  int n_err = 0;

  // ---------------- passive monitor ----------------
  int          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] txd [$];
  logic [26:0] txr [$];
  int          start_cyc [$];
  int          stop_cyc [$];
  logic        m_sda;
  logic        m_pscl = 1'b1;
  logic        m_psda = 1'b1;
  logic        m_pdone = 1'b0;
  logic        m_pbusy = 1'b0;
  logic        m_in = 1'b0;
  int          m_n = 0;
  logic [26:0] m_bits = '0;
  logic [26:0] m_rel = '0;
  int          done_rises = 0;
  int          done_bad = 0;

  always @(negedge clk) begin
    m_sda = bus.sio_d_oe ? bus.sio_d_out : 1'b1;
    if (bus.sio_c && m_pscl && m_psda && !m_sda) begin
      m_in = 1'b1;
      m_n = 0;
      m_bits = '0;
      m_rel = '0;
      start_cyc.push_back(cyc);
    end else if (bus.sio_c && m_pscl && !m_psda && m_sda) begin
      stop_cyc.push_back(cyc);
      // 27 data clocks plus the STOP clock rise
      if (m_in && m_n == 28) begin
        txd.push_back({m_bits[26:19], m_bits[17:10], m_bits[8:1]});
        txr.push_back(m_rel);
      end
      m_in = 1'b0;
    end else if (bus.sio_c && !m_pscl && m_in) begin
      if (m_n < 27) begin
        m_bits[26-m_n] = m_sda;
        m_rel[26-m_n]  = !bus.sio_d_oe;
      end
      m_n++;
    end
    if (bus.done && !m_pdone) begin
      done_rises++;
      if (bus.busy || !m_pbusy) done_bad++;
    end
    m_pscl  = bus.sio_c;
    m_psda  = m_sda;
    m_pdone = bus.done;
    m_pbusy = bus.busy;
  end

  // ---------------- helpers ----------------
  task automatic wait_txq(input int n, input int budget, output bit ok);
    int k = 0;
    ok = 1'b1;
    while (txd.size() < n) begin
      if (k >= budget) begin ok = 1'b0; break; end
      @(posedge clk);
      k++;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k = 0;
    ok = 1'b1;
    while (!bus.done) begin
      if (k >= budget) begin ok = 1'b0; break; end
      @(posedge clk);
      k++;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int lows = 0;
    repeat (3) @(negedge clk);
    n_vec++; if (bus.sio_c !== 1'b1) begin n_err++; $display("FAIL rst_sio_c got %b want 1", bus.sio_c); end
    n_vec++; if (bus.sio_d_oe !== 1'b0) begin n_err++; $display("FAIL rst_oe got %b want 0", bus.sio_d_oe); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL rst_done got %b want 0", bus.done); end
    n_vec++; if (bus.cfg_idx !== 6'd0) begin n_err++; $display("FAIL rst_idx got %0d want 0", bus.cfg_idx); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL busy_after_rst got %b want 1", bus.busy); end
    repeat (20) begin
      @(negedge clk);
      if (bus.sio_c !== 1'b1) lows++;
    end
    n_vec++; if (lows != 0) begin n_err++; $display("FAIL powerup_quiet sio_c low %0d cycles want 0", lows); end
  endtask

  task automatic test_first_txn();
    bit ok;
    wait_txq(1, 2000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL txn0_timeout got %0d writes want 1", txd.size()); end
    if (ok) begin
      n_vec++; if (txd[0] !== 24'h421280) begin n_err++; $display("FAIL txn0_bytes got %h want 421280", txd[0]); end
      n_vec++; if (txr[0] !== REL_MASK) begin n_err++; $display("FAIL txn0_release got %b want %b", txr[0], REL_MASK); end
      n_vec++; if (start_cyc.size() != 1) begin n_err++; $display("FAIL txn0_starts got %0d want 1", start_cyc.size()); end
    end
  endtask

  task automatic test_delay_gap();
    bit ok;
    wait_txq(2, 2000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL txn1_timeout got %0d writes want 2", txd.size()); end
    if (ok) begin
      n_vec++; if (txd[1] !== 24'h421214) begin n_err++; $display("FAIL txn1_bytes got %h want 421214", txd[1]); end
      n_vec++; if (start_cyc[1] - stop_cyc[0] < 36) begin n_err++; $display("FAIL delay_gap got %0d cycles want >=36", start_cyc[1] - stop_cyc[0]); end
    end
  endtask

  task automatic test_full_run();
    bit ok;
    int bad = 0;
    wait_txq(3, 2000, ok);
    pulse_start();                      // must be ignored while busy
    wait_done(20000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL run1_done_timeout got done=%b want 1", bus.done); end
    repeat (5) @(negedge clk);
    n_vec++; if (txd.size() != NWR) begin n_err++; $display("FAIL run1_count got %0d want %0d", txd.size(), NWR); end
    for (int i = 0; i < NWR && i < txd.size(); i++)
      if (txd[i] !== exp_tx[i] || txr[i] !== REL_MASK) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL run1_stream got %0d bad writes want 0", bad); end
    n_vec++; if (done_rises != 1 || done_bad != 0) begin n_err++; $display("FAIL run1_done_edge got rises=%0d bad=%0d want 1/0", done_rises, done_bad); end
    n_vec++; if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL run1_hold got done=%b busy=%b want 1/0", bus.done, bus.busy); end
  endtask

  task automatic test_restart();
    bit ok;
    int bad = 0;
    int base = txd.size();
    pulse_start();
    n_vec++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin n_err++; $display("FAIL restart_status got done=%b busy=%b want 0/1", bus.done, bus.busy); end
    wait_done(20000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL run2_done_timeout got done=%b want 1", bus.done); end
    repeat (5) @(negedge clk);
    n_vec++; if (txd.size() - base != NWR) begin n_err++; $display("FAIL run2_count got %0d want %0d", txd.size() - base, NWR); end
    for (int i = 0; i < NWR && base + i < txd.size(); i++)
      if (txd[base+i] !== exp_tx[i] || txr[base+i] !== REL_MASK) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL run2_stream got %0d bad writes want 0", bad); end
    n_vec++; if (done_rises != 2 || done_bad != 0) begin n_err++; $display("FAIL run2_done_edge got rises=%0d bad=%0d want 2/0", done_rises, done_bad); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int k = 0;
    int sbase = start_cyc.size();
    int base;
    pulse_start();
    // wait until the monitor is inside the reg byte of the first write
    while (!(start_cyc.size() > sbase && m_in && m_n >= 12) && k < 2000) begin
      @(posedge clk);
      k++;
    end
    n_vec++; if (k >= 2000) begin n_err++; $display("FAIL midrst_reach got bits=%0d want >=12", m_n); end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    n_vec++; if (bus.sio_c !== 1'b1 || bus.sio_d_oe !== 1'b0) begin n_err++; $display("FAIL midrst_bus got sio_c=%b oe=%b want 1/0", bus.sio_c, bus.sio_d_oe); end
    n_vec++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cfg_idx !== 6'd0) begin n_err++; $display("FAIL midrst_status got busy=%b done=%b idx=%0d want 0/0/0", bus.busy, bus.done, bus.cfg_idx); end
    repeat (3) @(negedge clk);
    base = txd.size();
    reset = 1'b0;
    wait_txq(base + 1, 2000, ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL midrst_rerun_timeout got %0d writes want 1", txd.size() - base); end
    if (ok) begin
      n_vec++; if (txd[base] !== 24'h421280 || txr[base] !== REL_MASK) begin n_err++; $display("FAIL midrst_rerun got %h/%b want 421280/%b", txd[base], txr[base], REL_MASK); end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_first_txn();
    test_delay_gap();
    test_full_run();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
